// File: rtl/dspl_mux_drv.sv
// dspl_mux_drv: time-multiplexed 7-segment display driver.
//   Holds one 7-bit register per digit ({blink, enable, hex, dp}) and scans
//   the digits one slot at a time. Each slot lasts TICK_COUNT clocks, and the
//   digit is lit for a brightness-dependent fraction of the slot.
// Ports:
//   clock, reset       system clock; asynchronous, active-high reset
//   wr_en/addr/data    digit register write port
//   wr_ack / wr_err    one-cycle pulses the cycle after an accepted or rejected write
//   brightness         duty level, 0 = 1/16 .. 15 = 16/16
//   an                 active-low anodes, bit i = digit i
//   dec_cat            active-low cathodes {a,b,c,d,e,f,g,dp}
//   scan_idx           digit owning the current slot
module dspl_mux_drv #(
  parameter int NUM_DIGITS  = 8,
  parameter int TICK_COUNT  = 100000,
  parameter int BLINK_SCANS = 250
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [6:0]            wr_data,
  output logic                  wr_ack,
  output logic                  wr_err,
  input  logic [3:0]            brightness,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            dec_cat,
  output logic [3:0]            scan_idx
);
  localparam int TW = $clog2(TICK_COUNT);
  // Wide enough for 16*TICK_COUNT, so the duty compare never overflows.
  localparam int PW = TW + 5;
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  logic [TW-1:0]                tick_cnt;
  logic [3:0]                   scan;
  logic [BW-1:0]                blink_cnt;
  logic                         blink_phase;
  logic [NUM_DIGITS-1:0][6:0]   digit_reg;
  logic [6:0]                   lat_digit;
  logic [3:0]                   lat_bright;

  logic                         tick_wrap, scan_wrap, wr_ok, lit;
  logic [6:0]                   sel_digit, cur_digit;
  logic [3:0]                   cur_bright;
  logic [PW-1:0]                duty_lhs, duty_rhs;
  logic [NUM_DIGITS-1:0]        an_next;
  logic [7:0]                   dec_next;

  function automatic logic [6:0] font(input logic [3:0] h);
    case (h)
      4'h0: font = 7'b0000001;
      4'h1: font = 7'b1001111;
      4'h2: font = 7'b0010010;
      4'h3: font = 7'b0000110;
      4'h4: font = 7'b1001100;
      4'h5: font = 7'b0100100;
      4'h6: font = 7'b0100000;
      4'h7: font = 7'b0001111;
      4'h8: font = 7'b0000000;
      4'h9: font = 7'b0000100;
      4'hA: font = 7'b0001000;
      4'hB: font = 7'b1100000;
      4'hC: font = 7'b0110001;
      4'hD: font = 7'b1000010;
      4'hE: font = 7'b0110000;
      default: font = 7'b0111000;
    endcase
  endfunction

  assign tick_wrap = (tick_cnt == TW'(TICK_COUNT - 1));
  assign scan_wrap = tick_wrap && (scan == 4'(NUM_DIGITS - 1));
  assign wr_ok     = ({1'b0, wr_addr} < 5'(NUM_DIGITS));
  assign scan_idx  = scan;

  always_comb begin
    sel_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (scan == 4'(i)) sel_digit = digit_reg[i];
  end

  // On tick 0 the latch is being loaded this very edge, so read through it;
  // for the rest of the slot only the latched copy is used, which keeps
  // mid-slot writes and brightness changes out of the current slot.
  assign cur_digit  = (tick_cnt == '0) ? sel_digit  : lat_digit;
  assign cur_bright = (tick_cnt == '0) ? brightness : lat_bright;

  assign duty_lhs = PW'(tick_cnt) << 4;
  assign duty_rhs = (PW'(cur_bright) + PW'(1)) * PW'(TICK_COUNT);

  assign lit = cur_digit[5] && (duty_lhs < duty_rhs) && !(cur_digit[6] && blink_phase);

  always_comb begin
    an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (lit && scan == 4'(i)) an_next[i] = 1'b0;
    dec_next = lit ? {font(cur_digit[4:1]), ~cur_digit[0]} : 8'hFF;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt    <= '0;
      scan        <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      digit_reg   <= '0;
      lat_digit   <= '0;
      lat_bright  <= '0;
      an          <= '1;
      dec_cat     <= 8'hFF;
      wr_ack      <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
      if (tick_wrap) scan <= scan_wrap ? 4'd0 : scan + 4'd1;
      if (scan_wrap) begin
        if (blink_cnt == BW'(BLINK_SCANS - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
      // Latch samples the register before this edge's write lands.
      if (tick_cnt == '0) begin
        lat_digit  <= sel_digit;
        lat_bright <= brightness;
      end
      for (int i = 0; i < NUM_DIGITS; i++)
        if (wr_en && wr_addr == 4'(i)) digit_reg[i] <= wr_data;
      an      <= an_next;
      dec_cat <= dec_next;
      wr_ack  <= wr_en && wr_ok;
      wr_err  <= wr_en && !wr_ok;
    end
  end
endmodule

// File: tb/tb_dspl_mux_drv.sv
// Testbench for dspl_mux_drv (4 digits, 16-cycle slots, 2 scans per blink half).
// The reference model tracks the absolute cycle count since reset release and
// derives slot, tick and blink phase from it arithmetically.
module tb_dspl_mux_drv;
  localparam int N = 4, T = 16, B = 2;

  logic       clock = 1'b0, reset = 1'b1, wr_en = 1'b0;
  logic [3:0] wr_addr = '0, brightness = '0;
  logic [6:0] wr_data = '0;
  logic       wr_ack, wr_err;
  logic [N-1:0] an;
  logic [7:0] dec_cat;
  logic [3:0] scan_idx;

  dspl_mux_drv #(.NUM_DIGITS(N), .TICK_COUNT(T), .BLINK_SCANS(B)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
    .brightness(brightness), .an(an), .dec_cat(dec_cat), .scan_idx(scan_idx)
  );

  always #5 clock = ~clock;

  logic [6:0] font [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int total = 0, bad = 0;
  int cyc = 0;
  int lit_cnt = 0;
  logic [6:0] mreg [N];
  logic [6:0] snap;
  logic [3:0] sbr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    cyc = 0;
    snap = '0;
    sbr = '0;
    for (int i = 0; i < N; i++) mreg[i] = '0;
  endtask

  // One clock: drive inputs, predict the registered outputs for the current
  // state, advance, then compare.
  task automatic step(input logic en, input logic [3:0] a, input logic [6:0] d,
                      input logic [3:0] br);
    int t, slot, phase;
    logic lit, eack, eerr;
    logic [N-1:0] ean;
    logic [7:0] edec;
    wr_en = en; wr_addr = a; wr_data = d; brightness = br;
    t     = cyc % T;
    slot  = (cyc / T) % N;
    phase = (cyc / (T * N * B)) % 2;
    if (t == 0) begin
      snap = mreg[slot];
      sbr  = br;
    end
    lit  = snap[5] && (t * 16 < (int'(sbr) + 1) * T) && !(snap[6] && phase == 1);
    ean  = lit ? ~(4'b0001 << slot) : 4'hF;
    edec = lit ? {font[snap[4:1]], ~snap[0]} : 8'hFF;
    eack = en && (int'(a) < N);
    eerr = en && (int'(a) >= N);
    if (eack) mreg[a[1:0]] = d;
    @(posedge clock);
    #1;
    cyc++;
    chk("an", 32'(an), 32'(ean));
    chk("dec_cat", 32'(dec_cat), 32'(edec));
    chk("wr_ack", 32'(wr_ack), 32'(eack));
    chk("wr_err", 32'(wr_err), 32'(eerr));
    chk("scan_idx", 32'(scan_idx), 32'((cyc / T) % N));
  endtask

  task automatic idle(input int n, input logic [3:0] br);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 7'd0, br);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_dec", 32'(dec_cat), 32'hFF);
    chk("rst_ack", 32'(wr_ack), 32'h0);
    chk("rst_err", 32'(wr_err), 32'h0);
    chk("rst_scan", 32'(scan_idx), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    model_clear();

    // Digit 0 = '3' at full brightness; write lands on slot-0 start so this
    // pass stays dark and the next pass shows it.
    step(1'b1, 4'd0, 7'b0_1_0011_0, 4'd15);
    idle(127, 4'd15);

    // Digit 2 at brightness 3: lit 4 of 16 cycles per slot.
    step(1'b1, 4'd2, 7'b0_1_0111_1, 4'd3);
    while (cyc % (T * N) != 0) step(1'b0, 4'd0, 7'd0, 4'd3);
    lit_cnt = 0;
    for (int i = 0; i < T * N; i++) begin
      step(1'b0, 4'd0, 7'd0, 4'd3);
      if (an[2] == 1'b0) lit_cnt++;
    end
    chk("duty_cnt", 32'(lit_cnt), 32'd4);

    // Out-of-range write, then back-to-back mixed writes.
    step(1'b1, 4'd5, 7'h7F, 4'd15);
    step(1'b1, 4'd3, 7'b0_1_1010_0, 4'd15);
    step(1'b1, 4'd9, 7'h55, 4'd15);
    step(1'b1, 4'd3, 7'b0_1_1011_1, 4'd15);
    idle(64, 4'd15);

    // Blinking digit 1 over two full blink periods.
    step(1'b1, 4'd1, 7'b1_1_0001_0, 4'd15);
    idle(520, 4'd15);

    // Write digit 0 at tick 5 of slot 0.
    while (cyc % (T * N) != 5) step(1'b0, 4'd0, 7'd0, 4'd15);
    step(1'b1, 4'd0, 7'b0_1_0101_0, 4'd15);
    idle(80, 4'd15);

    // Random traffic.
    for (int i = 0; i < 900; i++)
      step($urandom_range(0, 2) == 0, 4'($urandom_range(0, 7)),
           7'($urandom), 4'($urandom));

    // Reset at tick 9 of slot 3 with an ack pending.
    while (cyc % (T * N) != 56) step(1'b0, 4'd0, 7'd0, 4'd15);
    step(1'b1, 4'd1, 7'b0_1_1000_0, 4'd15);
    reset = 1'b1;
    #1;
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_dec", 32'(dec_cat), 32'hFF);
    chk("mid_rst_ack", 32'(wr_ack), 32'h0);
    chk("mid_rst_scan", 32'(scan_idx), 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    wr_en = 1'b0;
    reset = 1'b0;
    model_clear();
    idle(128, 4'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
